// File: rtl/ttt_pkg.sv
// Shared types and helpers for the tic-tac-toe keypad front end.
package ttt_pkg;
  localparam int GRID_DIM  = 3;
  localparam int NUM_CELLS = 9;

  typedef logic [3:0]           cell_idx_t;
  typedef logic [NUM_CELLS-1:0] cell_mask_t;

  typedef enum logic {RELEASED = 1'b0, PRESSED = 1'b1} press_state_e;

  function automatic logic [3:0] mask_popcount(input cell_mask_t m);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_CELLS; i++) cnt = cnt + {3'b000, m[i]};
    return cnt;
  endfunction

  function automatic cell_idx_t mask_to_idx(input cell_mask_t m);
    cell_idx_t idx;
    idx = '0;
    for (int i = 0; i < NUM_CELLS; i++) if (m[i]) idx = 4'(i);
    return idx;
  endfunction
endpackage

// File: rtl/ttt_debounce_filter.sv
// Full-matrix debounce: a snapshot must repeat DEBOUNCE_SCANS times in a row
// before it becomes the stable key state.
module ttt_debounce_filter
  import ttt_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_done_i,
  input  cell_mask_t snap_i,
  output logic       stable_upd_o,
  output cell_mask_t stable_nxt_o
);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  logic [CW-1:0] count_q, count_d;
  cell_mask_t    prev_q, prev_d;
  cell_mask_t    stable_q, stable_d;
  logic          match;

  // count_q == 0 only before the first scan, so that scan is always a mismatch
  always_comb begin
    count_d      = count_q;
    prev_d       = prev_q;
    stable_d     = stable_q;
    stable_upd_o = 1'b0;
    match        = (count_q != '0) && (snap_i == prev_q);
    if (scan_done_i) begin
      if (match) begin
        if (count_q != CW'(DEBOUNCE_SCANS)) count_d = count_q + CW'(1);
      end else begin
        count_d = CW'(1);
        prev_d  = snap_i;
      end
      if (count_d == CW'(DEBOUNCE_SCANS)) begin
        stable_d     = snap_i;
        stable_upd_o = 1'b1;
      end
    end
  end

  assign stable_nxt_o = stable_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      prev_q   <= '0;
      stable_q <= '0;
    end else begin
      count_q  <= count_d;
      prev_q   <= prev_d;
      stable_q <= stable_d;
    end
  end
endmodule

// File: rtl/ttt_keypad_scanner.sv
// 3x3 keypad scanner: column sequencer, row sampling, debounce and a press FSM
// emitting one single-cycle event per clean single-key press.
module ttt_keypad_scanner
  import ttt_pkg::*;
#(
  parameter int SCAN_CYCLES    = 16,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [GRID_DIM-1:0] row_in,
  output logic [GRID_DIM-1:0] col_out,
  output logic                press_valid,
  output cell_idx_t           press_idx,
  output cell_mask_t          press_onehot,
  output logic                multi_key
);
  localparam int PW = $clog2(SCAN_CYCLES);

  logic [PW-1:0]       phase_q, phase_d;
  logic [GRID_DIM-1:0] col_q, col_d;
  cell_mask_t          snap_q, snap_d;
  press_state_e        state_q, state_d;
  logic                valid_q, valid_d;
  cell_idx_t           idx_q, idx_d;
  cell_mask_t          onehot_q, onehot_d;
  logic                multi_q, multi_d;
  logic                sample, scan_done, stable_upd;
  cell_mask_t          stable_nxt;

  assign sample    = (phase_q == PW'(SCAN_CYCLES - 1));
  assign scan_done = sample && col_q[GRID_DIM-1];

  always_comb begin
    phase_d = phase_q + PW'(1);
    col_d   = col_q;
    if (sample) begin
      phase_d = '0;
      col_d   = {col_q[GRID_DIM-2:0], col_q[GRID_DIM-1]};
    end
  end

  // snap_d carries the column being sampled now, so the last column is
  // visible to the debounce compare on the same edge that completes the scan
  always_comb begin
    snap_d = snap_q;
    for (int r = 0; r < GRID_DIM; r++)
      for (int c = 0; c < GRID_DIM; c++)
        if (col_q[c]) snap_d[GRID_DIM*r+c] = row_in[r];
  end

  ttt_debounce_filter #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk         (clk),
    .reset       (reset),
    .scan_done_i (scan_done),
    .snap_i      (snap_d),
    .stable_upd_o(stable_upd),
    .stable_nxt_o(stable_nxt)
  );

  always_comb begin
    state_d  = state_q;
    valid_d  = 1'b0;
    idx_d    = '0;
    onehot_d = '0;
    multi_d  = multi_q;
    if (stable_upd) begin
      multi_d = (mask_popcount(stable_nxt) >= 4'd2);
      case (state_q)
        RELEASED: begin
          if (stable_nxt != '0) begin
            state_d = PRESSED;
            if (mask_popcount(stable_nxt) == 4'd1) begin
              valid_d  = 1'b1;
              idx_d    = mask_to_idx(stable_nxt);
              onehot_d = stable_nxt;
            end
          end
        end
        PRESSED:  if (stable_nxt == '0) state_d = RELEASED;
        default:  state_d = RELEASED;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q  <= '0;
      col_q    <= 3'b001;
      snap_q   <= '0;
      state_q  <= RELEASED;
      valid_q  <= 1'b0;
      idx_q    <= '0;
      onehot_q <= '0;
      multi_q  <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      col_q    <= col_d;
      if (sample) snap_q <= snap_d;
      state_q  <= state_d;
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
      multi_q  <= multi_d;
    end
  end

  assign col_out      = col_q;
  assign press_valid  = valid_q;
  assign press_idx    = idx_q;
  assign press_onehot = onehot_q;
  assign multi_key    = multi_q;
endmodule

// File: tb/tb_ttt_keypad_scanner.sv
// Self-checking bench: keypad matrix model driven by a key mask, scan-level reference model.
module tb_ttt_keypad_scanner;
  localparam int SC = 4;
  localparam int D  = 2;

  logic       clk, reset;
  logic [2:0] row_in, col_out;
  logic       press_valid, multi_key;
  logic [3:0] press_idx;
  logic [8:0] press_onehot;

  ttt_keypad_scanner #(.SCAN_CYCLES(SC), .DEBOUNCE_SCANS(D)) dut (
    .clk(clk), .reset(reset), .row_in(row_in), .col_out(col_out),
    .press_valid(press_valid), .press_idx(press_idx),
    .press_onehot(press_onehot), .multi_key(multi_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [8:0] keys;
  always_comb begin
    row_in = 3'b000;
    for (int c = 0; c < 3; c++)
      if (col_out[c])
        for (int r = 0; r < 3; r++)
          if (keys[3*r+c]) row_in[r] = 1'b1;
  end

  logic [17:0] obs;
  assign obs = {col_out, press_valid, press_idx, press_onehot, multi_key};
  localparam logic [17:0] RST_VEC = {3'b001, 1'b0, 4'h0, 9'h000, 1'b0};

  int vectors = 0, miscompares = 0;

  // reference model: expected outputs for the current cycle n
  int         n;
  logic [8:0] hist[$];
  logic [8:0] cur_snap, m_stable;
  bit         m_pressed;
  logic [2:0] exp_col;
  logic       exp_valid, exp_multi;
  logic [3:0] exp_idx;
  logic [8:0] exp_onehot;

  int         obs_pulses, obs_cyc, obs_b2b;
  logic [3:0] obs_idx;
  bit         obs_multi_seen, prev_valid;

  function automatic logic [17:0] exp_vec();
    return {exp_col, exp_valid, exp_idx, exp_onehot, exp_multi};
  endfunction

  task automatic model_clear();
    n = 0; hist.delete(); cur_snap = '0; m_stable = '0; m_pressed = 0;
    exp_col = 3'b001; exp_valid = 0; exp_idx = '0; exp_onehot = '0; exp_multi = 0;
    obs_pulses = 0; obs_cyc = -1; obs_idx = '0; obs_b2b = 0;
    obs_multi_seen = 0; prev_valid = 0;
  endtask

  // Record observations for cycle n, advance the model across the clock edge, land mid next cycle.
  task automatic adv();
    int  col;
    bit  same;
    if (press_valid === 1'b1) begin
      obs_pulses++; obs_cyc = n; obs_idx = press_idx;
      if (prev_valid) obs_b2b++;
    end
    prev_valid = (press_valid === 1'b1);
    if (multi_key === 1'b1) obs_multi_seen = 1;
    exp_valid = 0; exp_idx = '0; exp_onehot = '0;
    col = (n / SC) % 3;
    if (n % SC == SC - 1)
      for (int r = 0; r < 3; r++) cur_snap[3*r+col] = keys[3*r+col];
    if (n % (3*SC) == 3*SC - 1) begin
      hist.push_back(cur_snap);
      if (hist.size() > D) void'(hist.pop_front());
      same = (hist.size() == D);
      foreach (hist[i]) if (hist[i] != cur_snap) same = 0;
      if (same) begin
        m_stable = cur_snap;
        if (!m_pressed && $countones(m_stable) == 1) begin
          exp_valid  = 1;
          exp_onehot = m_stable;
          for (int b = 0; b < 9; b++) if (m_stable[b]) exp_idx = 4'(b);
        end
        if (m_stable != 0) m_pressed = 1;
        else m_pressed = 0;
        exp_multi = ($countones(m_stable) >= 2);
      end
    end
    n++;
    exp_col = 3'(1 << ((n / SC) % 3));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    model_clear();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    keys = 9'h010;
    for (int i = 0; i < 24; i++) begin
      vectors++;
      if (obs !== exp_vec()) begin miscompares++; $display("FAIL reset_pre cyc %0d: got %h want %h", n, obs, exp_vec()); end
      adv();
    end
    vectors++;
    if (press_valid !== 1'b1) begin miscompares++; $display("FAIL reset_pulse_live: got %b want 1", press_valid); end
    reset = 1'b1;
    #1;
    vectors++;
    if (obs !== RST_VEC) begin miscompares++; $display("FAIL reset_values: got %h want %h", obs, RST_VEC); end
    keys = '0;
    do_reset();
    for (int i = 0; i < 200; i++) begin
      vectors++;
      if (obs !== exp_vec()) begin miscompares++; $display("FAIL idle cyc %0d: got %h want %h", n, obs, exp_vec()); end
      adv();
    end
    vectors++;
    if (obs_pulses != 0 || obs_multi_seen) begin miscompares++; $display("FAIL idle_events: got pulses=%0d multi=%0b want 0 0", obs_pulses, obs_multi_seen); end
  endtask

  task automatic test_single_press();
    do_reset();
    keys = 9'h010;
    for (int i = 0; i < 60; i++) begin
      vectors++;
      if (obs !== exp_vec()) begin miscompares++; $display("FAIL single cyc %0d: got %h want %h", n, obs, exp_vec()); end
      adv();
    end
    vectors++;
    if (obs_pulses != 1 || obs_cyc != 24 || obs_idx != 4'd4) begin
      miscompares++; $display("FAIL single_latency: got pulses=%0d cyc=%0d idx=%0d want 1 24 4", obs_pulses, obs_cyc, obs_idx);
    end
  endtask

  task automatic test_repress();
    do_reset();
    for (int i = 0; i < 130; i++) begin
      keys = (i < 40 || i >= 70) ? 9'h100 : 9'h000;
      vectors++;
      if (obs !== exp_vec()) begin miscompares++; $display("FAIL repress cyc %0d: got %h want %h", n, obs, exp_vec()); end
      adv();
    end
    vectors++;
    if (obs_pulses != 2 || obs_idx != 4'd8) begin
      miscompares++; $display("FAIL repress_count: got pulses=%0d idx=%0d want 2 8", obs_pulses, obs_idx);
    end
  endtask

  task automatic test_bounce();
    do_reset();
    for (int i = 0; i < 110; i++) begin
      keys = (i >= 60 || ((i / 5) % 2) == 0) ? 9'h004 : 9'h000;
      vectors++;
      if (obs !== exp_vec()) begin miscompares++; $display("FAIL bounce cyc %0d: got %h want %h", n, obs, exp_vec()); end
      adv();
    end
    vectors++;
    if (obs_cyc < 60 || obs_cyc > 84 || obs_idx != 4'd2) begin
      miscompares++; $display("FAIL bounce_hold: got last pulse cyc=%0d idx=%0d want 60..84 idx 2", obs_cyc, obs_idx);
    end
  endtask

  task automatic test_multi();
    do_reset();
    for (int i = 0; i < 160; i++) begin
      if (i < 40)       keys = 9'h041;
      else if (i < 80)  keys = 9'h001;
      else if (i < 120) keys = 9'h000;
      else              keys = 9'h001;
      vectors++;
      if (obs !== exp_vec()) begin miscompares++; $display("FAIL multi cyc %0d: got %h want %h", n, obs, exp_vec()); end
      adv();
    end
    vectors++;
    if (!obs_multi_seen || obs_pulses != 1 || obs_idx != 4'd0 || obs_cyc != 144) begin
      miscompares++; $display("FAIL multi_lockout: got multi=%0b pulses=%0d idx=%0d cyc=%0d want 1 1 0 144", obs_multi_seen, obs_pulses, obs_idx, obs_cyc);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    keys = 9'h020;
    for (int i = 0; i < 22; i++) begin
      vectors++;
      if (obs !== exp_vec()) begin miscompares++; $display("FAIL rstmid_pre cyc %0d: got %h want %h", n, obs, exp_vec()); end
      adv();
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (obs !== RST_VEC) begin miscompares++; $display("FAIL rstmid_async: got %h want %h", obs, RST_VEC); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (obs !== RST_VEC) begin miscompares++; $display("FAIL rstmid_hold %0d: got %h want %h", i, obs, RST_VEC); end
    end
    model_clear();
    reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      vectors++;
      if (obs !== exp_vec()) begin miscompares++; $display("FAIL rstmid_post cyc %0d: got %h want %h", n, obs, exp_vec()); end
      adv();
    end
    vectors++;
    if (obs_pulses != 1 || obs_cyc != 24 || obs_idx != 4'd5) begin
      miscompares++; $display("FAIL rstmid_latency: got pulses=%0d cyc=%0d idx=%0d want 1 24 5", obs_pulses, obs_cyc, obs_idx);
    end
  endtask

  task automatic test_random();
    int         hold;
    logic [8:0] k;
    do_reset();
    for (int s = 0; s < 40; s++) begin
      hold = $urandom_range(1, 40);
      case ($urandom_range(0, 3))
        0:       k = 9'h000;
        1, 2:    k = 9'(1 << $urandom_range(0, 8));
        default: k = 9'($urandom);
      endcase
      for (int i = 0; i < hold; i++) begin
        keys = k;
        vectors++;
        if (obs !== exp_vec()) begin miscompares++; $display("FAIL random cyc %0d: got %h want %h", n, obs, exp_vec()); end
        adv();
      end
    end
    vectors++;
    if (obs_b2b != 0) begin miscompares++; $display("FAIL back_to_back: got %0d adjacent pulses want 0", obs_b2b); end
  endtask

  initial begin
    reset = 1'b1;
    keys  = '0;
    model_clear();
    @(negedge clk);
    test_reset();
    test_single_press();
    test_repress();
    test_bounce();
    test_multi();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
